// File: rtl/fifo_burst_reader_if.sv
// Bundles the fifo read port and the downstream valid/ready stream seen by fifo_burst_reader.
// master = the reader; slave = the side that owns the fifo and the consumer.
interface fifo_burst_reader_if #(
    parameter int DWIDTH      = 16,
    parameter int COUNT_WIDTH = 7
);
    logic [DWIDTH-1:0]      fifo_dout;
    logic                   fifo_empty;
    logic [COUNT_WIDTH-1:0] fifo_data_count;
    logic                   fifo_rd_en;
    logic                   m_valid;
    logic                   m_ready;
    logic [DWIDTH-1:0]      m_data;
    logic                   m_last;

    modport master (
        input  fifo_dout, fifo_empty, fifo_data_count, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_dout, fifo_empty, fifo_data_count, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains an FWFT fifo in bursts of BURST_LEN words (or a timed-out partial burst) into a
// valid/ready stream through a 2-entry skid buffer; flush discards everything queued.
module fifo_burst_reader #(
    parameter int DWIDTH      = 16,
    parameter int COUNT_WIDTH = 7,
    parameter int BURST_LEN   = 8,
    parameter int TIMEOUT     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    fifo_burst_reader_if.master       bus,
    input  logic                      flush,
    output logic                      busy,
    output logic [31:0]               words_out
);
    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [COUNT_WIDTH-1:0] BURST_CNT  = COUNT_WIDTH'(BURST_LEN);
    localparam logic [WAIT_W-1:0]      WAIT_LIMIT = WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        FLUSH
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [COUNT_WIDTH-1:0] rem;
    logic [COUNT_WIDTH-1:0] rem_next;
    logic [WAIT_W-1:0]      wait_cnt;
    logic [WAIT_W-1:0]      wait_next;

    logic [DWIDTH-1:0]      skid_data0;
    logic [DWIDTH-1:0]      skid_data1;
    logic                   skid_last0;
    logic                   skid_last1;
    logic [1:0]             skid_cnt;

    logic                   out_valid;
    logic                   out_pop;
    logic                   skid_space;
    logic                   rd_en;
    logic                   push;
    logic                   push_last;
    logic                   full_start;
    logic                   part_start;

    assign out_valid  = (skid_cnt != 2'd0);
    assign out_pop    = out_valid & bus.m_ready;
    assign skid_space = (skid_cnt < 2'd2) | out_pop;
    assign full_start = (bus.fifo_data_count >= BURST_CNT);
    assign part_start = (TIMEOUT != 0) && (wait_cnt == WAIT_LIMIT) && !bus.fifo_empty;
    assign push_last  = (rem == COUNT_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rem      <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            rem      <= rem_next;
            wait_cnt <= wait_next;
        end
    end

    always_comb begin
        state_next = state;
        rem_next   = rem;
        wait_next  = wait_cnt;
        rd_en      = 1'b0;
        push       = 1'b0;
        if (flush) begin
            state_next = FLUSH;
            rem_next   = '0;
            wait_next  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (full_start) begin
                        state_next = BURST;
                        rem_next   = BURST_CNT;
                        wait_next  = '0;
                    end else if (part_start) begin
                        state_next = BURST;
                        rem_next   = bus.fifo_data_count;
                        wait_next  = '0;
                    end else if (bus.fifo_empty) begin
                        wait_next = '0;
                    end else if (TIMEOUT != 0) begin
                        wait_next = wait_cnt + WAIT_W'(1);
                    end
                end
                BURST: begin
                    wait_next = '0;
                    // A partial start can latch rem=0 if the count lags the empty flag; leave at once.
                    if (rem == '0) begin
                        state_next = IDLE;
                    end else if (!bus.fifo_empty && skid_space) begin
                        rd_en    = 1'b1;
                        push     = 1'b1;
                        rem_next = rem - COUNT_WIDTH'(1);
                        if (push_last) begin
                            state_next = IDLE;
                        end
                    end
                end
                FLUSH: begin
                    wait_next = '0;
                    rd_en     = !bus.fifo_empty;
                    if (bus.fifo_empty) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Skid buffer: entry 0 is the head; a simultaneous push and pop keeps the count and order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_data0 <= '0;
            skid_data1 <= '0;
            skid_last0 <= 1'b0;
            skid_last1 <= 1'b0;
            skid_cnt   <= 2'd0;
        end else if (flush) begin
            skid_cnt <= 2'd0;
        end else begin
            case ({push, out_pop})
                2'b10: begin
                    if (skid_cnt == 2'd0) begin
                        skid_data0 <= bus.fifo_dout;
                        skid_last0 <= push_last;
                    end else begin
                        skid_data1 <= bus.fifo_dout;
                        skid_last1 <= push_last;
                    end
                    skid_cnt <= skid_cnt + 2'd1;
                end
                2'b01: begin
                    skid_data0 <= skid_data1;
                    skid_last0 <= skid_last1;
                    skid_cnt   <= skid_cnt - 2'd1;
                end
                2'b11: begin
                    if (skid_cnt == 2'd1) begin
                        skid_data0 <= bus.fifo_dout;
                        skid_last0 <= push_last;
                    end else begin
                        skid_data0 <= skid_data1;
                        skid_last0 <= skid_last1;
                        skid_data1 <= bus.fifo_dout;
                        skid_last1 <= push_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_out <= '0;
        end else if (out_pop) begin
            words_out <= words_out + 32'd1;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = out_valid;
    assign bus.m_data     = skid_data0;
    assign bus.m_last     = skid_last0;
    assign busy           = (state != IDLE) || out_valid;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-backed FWFT fifo model feeds the DUT and a scoreboard
// of expected {data,last} beats is checked as the consumer accepts words.
module tb_fifo_burst_reader;
    localparam int DW = 16;
    localparam int CW = 7;
    localparam int BL = 8;
    localparam int TO = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] words_out;

    fifo_burst_reader_if #(.DWIDTH(DW), .COUNT_WIDTH(CW)) bus ();

    fifo_burst_reader #(
        .DWIDTH(DW),
        .COUNT_WIDTH(CW),
        .BURST_LEN(BL),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master),
        .flush(flush),
        .busy(busy),
        .words_out(words_out)
    );

    always #5 clk = ~clk;

    beat_t         exp_q[$];
    logic [DW-1:0] fifo_q[$];
    int            tests = 0;
    int            failed = 0;
    logic [31:0]   exp_words = '0;
    logic          s_valid = 1'b0;
    logic          s_rd = 1'b0;
    logic          s_last = 1'b0;
    logic          s_busy = 1'b0;
    logic [DW-1:0] s_data = '0;

    task automatic fifo_outs();
        bus.fifo_empty      = (fifo_q.size() == 0);
        bus.fifo_dout       = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        bus.fifo_data_count = CW'(fifo_q.size());
    endtask

    // Loads n consecutive words at once; when tracked, beats are tagged last every BL words and at the end.
    task automatic write_words(input logic [DW-1:0] base, input int n, input bit track);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + DW'(i));
            if (track) begin
                b.data = base + DW'(i);
                b.last = (((i + 1) % BL) == 0) || (i == n - 1);
                exp_q.push_back(b);
            end
        end
        fifo_outs();
    endtask

    // One clock: sample at the falling edge (scoreboard + pop-on-empty guard), then update the fifo model after the rising edge.
    task automatic tick();
        beat_t e;
        @(negedge clk);
        s_valid = bus.m_valid;
        s_data  = bus.m_data;
        s_last  = bus.m_last;
        s_rd    = bus.fifo_rd_en;
        s_busy  = busy;
        if (s_rd) begin
            tests++;
            if (bus.fifo_empty !== 1'b0) begin
                failed++;
                $display("FAIL pop_on_empty: fifo_empty=%0b while fifo_rd_en=1, required 0", bus.fifo_empty);
            end
        end
        if (!rst && s_valid && bus.m_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_beat: got data=%h last=%0b, required no beat", s_data, s_last);
            end else begin
                e = exp_q.pop_front();
                if ({s_data, s_last} !== {e.data, e.last}) begin
                    failed++;
                    $display("FAIL beat: got data=%h last=%0b, required data=%h last=%0b", s_data, s_last, e.data, e.last);
                end
            end
        end
        @(posedge clk);
        #1;
        if (s_rd && fifo_q.size() != 0) fifo_q.delete(0);
        fifo_outs();
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((exp_q.size() != 0 || s_busy) && n < budget);
        if (exp_q.size() != 0 || s_busy) begin
            tests++;
            failed++;
            $display("FAIL drain_timeout: %0d beats outstanding busy=%0b after %0d cycles, required 0 and 0", exp_q.size(), s_busy, n);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        tests++; if (s_valid !== 1'b0) begin failed++; $display("FAIL reset_m_valid: got %0b required 0", s_valid); end
        tests++; if (s_rd !== 1'b0) begin failed++; $display("FAIL reset_rd_en: got %0b required 0", s_rd); end
        tests++; if ({s_data, s_last} !== '0) begin failed++; $display("FAIL reset_data: got %h/%0b required 0/0", s_data, s_last); end
        tests++; if (s_busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %0b required 0", s_busy); end
        tests++; if (words_out !== 32'd0) begin failed++; $display("FAIL reset_words_out: got %0d required 0", words_out); end
        rst = 1'b0;
        tick();
        tests++; if (s_busy !== 1'b0) begin failed++; $display("FAIL idle_busy: got %0b required 0", s_busy); end
    endtask

    task automatic test_single_burst();
        bus.m_ready = 1'b1;
        write_words(16'h0010, 8, 1'b1);
        wait_drain(60);
        exp_words += 32'd8;
        tests++; if (words_out !== exp_words) begin failed++; $display("FAIL single_words_out: got %0d required %0d", words_out, exp_words); end
    endtask

    task automatic test_timeout();
        int n = 0;
        write_words(16'h0020, 3, 1'b1);
        while (n < 60) begin
            tick();
            if (s_rd) break;
            n++;
        end
        tests++; if (n != TO + 1) begin failed++; $display("FAIL timeout_start: first pop after %0d cycles, required %0d", n, TO + 1); end
        wait_drain(40);
        exp_words += 32'd3;
        tests++; if (words_out !== exp_words) begin failed++; $display("FAIL timeout_words_out: got %0d required %0d", words_out, exp_words); end
    endtask

    task automatic test_stall();
        int pops = 0;
        int hold_bad = 0;
        int nv = 0;
        bus.m_ready = 1'b0;
        write_words(16'h0030, 8, 1'b1);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (s_rd) pops++;
            if (s_valid && ({s_data, s_last} !== {16'h0030, 1'b0})) hold_bad++;
        end
        tests++; if (pops != 2) begin failed++; $display("FAIL stall_pops: got %0d required 2", pops); end
        tests++; if (hold_bad != 0) begin failed++; $display("FAIL stall_hold: %0d cycles with changed data, required 0", hold_bad); end
        tests++; if (s_valid !== 1'b1) begin failed++; $display("FAIL stall_valid: got %0b required 1", s_valid); end
        bus.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (s_valid) nv++;
        end
        tests++; if (nv != 8) begin failed++; $display("FAIL stall_no_gap: %0d valid cycles of 8, required 8", nv); end
        wait_drain(20);
        exp_words += 32'd8;
        tests++; if (words_out !== exp_words) begin failed++; $display("FAIL stall_words_out: got %0d required %0d", words_out, exp_words); end
    endtask

    task automatic test_multi_burst();
        bus.m_ready = 1'b1;
        write_words(16'h0040, 20, 1'b1);
        wait_drain(200);
        exp_words += 32'd20;
        tests++; if (words_out !== exp_words) begin failed++; $display("FAIL multi_words_out: got %0d required %0d", words_out, exp_words); end
    endtask

    task automatic test_flush();
        int n = 0;
        bus.m_ready = 1'b0;
        write_words(16'h0060, 6, 1'b0);
        while (n < 60) begin
            tick();
            if (s_rd) break;
            n++;
        end
        tests++; if (!s_rd) begin failed++; $display("FAIL flush_start: no pop seen, required a partial burst"); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests++; if (s_valid !== 1'b1) begin failed++; $display("FAIL flush_skid_word: m_valid=%0b required 1", s_valid); end
        tests++; if (fifo_q.size() != 5) begin failed++; $display("FAIL flush_fifo_level: got %0d required 5", fifo_q.size()); end
        tick();
        tests++; if (s_valid !== 1'b0) begin failed++; $display("FAIL flush_valid_drop: got %0b required 0", s_valid); end
        wait_drain(40);
        tests++; if (fifo_q.size() != 0) begin failed++; $display("FAIL flush_drained: %0d words left, required 0", fifo_q.size()); end
        tests++; if (words_out !== exp_words) begin failed++; $display("FAIL flush_words_out: got %0d required %0d", words_out, exp_words); end
        bus.m_ready = 1'b1;
    endtask

    task automatic test_async_reset();
        bus.m_ready = 1'b1;
        write_words(16'h0070, 8, 1'b1);
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        tests++; if ({bus.m_valid, bus.fifo_rd_en, bus.m_last} !== 3'b000) begin failed++; $display("FAIL arst_flags: valid/rd/last=%b required 000", {bus.m_valid, bus.fifo_rd_en, bus.m_last}); end
        tests++; if (bus.m_data !== '0) begin failed++; $display("FAIL arst_data: got %h required 0", bus.m_data); end
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL arst_busy: got %0b required 0", busy); end
        tests++; if (words_out !== 32'd0) begin failed++; $display("FAIL arst_words_out: got %0d required 0", words_out); end
        fifo_q.delete();
        exp_q.delete();
        fifo_outs();
        exp_words = '0;
        tick();
        tick();
        #3 rst = 1'b0;
        tick();
        write_words(16'h0080, 8, 1'b1);
        wait_drain(60);
        exp_words += 32'd8;
        tests++; if (words_out !== exp_words) begin failed++; $display("FAIL arst_fresh_words_out: got %0d required %0d", words_out, exp_words); end
    endtask

    initial begin
        bus.m_ready = 1'b0;
        fifo_outs();
        test_reset();
        test_single_burst();
        test_timeout();
        test_stall();
        test_multi_burst();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units, required completion");
        $fatal(1);
    end
endmodule
